data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//   Direct-mapped, write-back, write-allocate data cache between the core's load/store stage and main_memory.
//   Serves 32-bit word accesses from 128-bit (`MEM_DATA_WIDTH) lines.
//   Drives main_memory's addr/data_to_write/wrt_en/data_to_read interface and models the memory access latency with an internal counter.
//   Stalls the pipeline on a miss.
// PARAMETERS
//   NUM_LINES    4    number of cache lines; power of 2; index = addr[4+:log2(NUM_LINES)]
//   MEM_LATENCY  5    cycles each memory read or write transaction occupies; >=1
//   LINE_WIDTH   `MEM_DATA_WIDTH (128)   line size in bits; offset = addr[3:0]
// PORTS
//   clk                input   1    clock, rising edge
//   reset              input   1    synchronous, active-high
//   req_valid          input   1    load/store request present
//   req_wrt_en         input   1    1=store, 0=load
//   req_addr           input   32   byte address; word select addr[3:2]; tag above index
//   req_wdata          input   32   store data
//   rsp_rdata          output  32   load data, valid when req_valid & !stall
//   stall              output  1    request not complete this cycle; requester holds req_* stable
//   mem_addr           output  32   line byte address to main_memory, low 4 bits zero
//   mem_data_to_write  output  128  line being written back
//   mem_wrt_en         output  1    main_memory write enable
//   mem_data_to_read   input   128  line returned by main_memory
// BEHAVIOUR
//   Reset: clears all valid/dirty bits, state=IDLE, counter=0, mem_wrt_en=0, mem_addr=0, mem_data_to_write=0.
//     Outputs are combinational from state, so stall=0 and rsp_rdata=0 in the cycle after reset.
//   FSM states: IDLE, EVICT, FILL.
//   IDLE, hit (valid & tag match):
//     stall=0.
//     Load: rsp_rdata = selected word, combinational, same cycle.
//     Store: word merged into line at posedge; dirty set.
//   IDLE, miss: stall=1; counter=MEM_LATENCY-1.
//     Victim valid & dirty -> EVICT; otherwise -> FILL.
//   EVICT:
//     mem_addr = {victim tag, index, 4'b0}; mem_data_to_write = victim line; mem_wrt_en=1.
//     All three are held stable for MEM_LATENCY cycles.
//     At counter==0: clear dirty, reload counter, go to FILL.
//   FILL:
//     mem_addr = {req_addr[31:4], 4'b0}; mem_wrt_en=0.
//     At counter==0: capture mem_data_to_read into the line; set tag, valid=1, dirty=0; go to IDLE.
//   Retry: the request then hits in IDLE.
//     Stall cycles: clean miss = 1+MEM_LATENCY; dirty miss = 1+2*MEM_LATENCY.
//   stall=1 whenever state!=IDLE. rsp_rdata=0 when no hit. req_valid=0 in IDLE -> no state change.
//   Changing req_* while stall=1 is a protocol violation; the bench asserts against it.
//   Reset mid-EVICT/FILL: transaction abandoned, line not updated, mem_wrt_en=0 next cycle.
//   Same-line conflict (tag differs, index equal) always evicts; no replacement choice.
//   Counter width clog2(MEM_LATENCY)+1; no wrap, reloaded on every state entry.
// CONFIGURATION
//   DCACHE_BYTE_EN defined:
//     Adds input req_byte (1).
//     Byte load: returns line byte at req_addr[3:0], little-endian, sign-extended to 32 bits.
//     Byte store: merges req_wdata[7:0] into that byte only; dirty set.
//   DCACHE_BYTE_EN undefined:
//     req_byte port absent; req_addr[1:0] ignored; word accesses only.
// TESTING
//   Reset, then load 0x0000_0040 with MEM_LATENCY=5 and memory line = 128'h...DDDD_CCCC_BBBB_AAAA (one 16-bit value per word):
//     -> stall high 6 cycles, mem_wrt_en=0, then rsp_rdata = word 0 of that line.
//   Store 0x1234_5678 to 0x44, then load 0x44:
//     -> no stall, rsp_rdata=32'h1234_5678, no memory traffic.
//   Load 0x0000_0080 (same index, dirty victim):
//     -> mem_wrt_en=1 for 5 cycles at mem_addr=0x40, mem_data_to_write word1=0x1234_5678, then 5 fill cycles;
//     -> stall 11 cycles total.
//   Reload 0x44:
//     -> clean miss, 6 stall cycles, rsp_rdata=32'h1234_5678 (write-back persisted).
//   Reset asserted in FILL cycle 3:
//     -> next cycle state IDLE, stall=0, mem_wrt_en=0; subsequent load of same address misses again.
//   DCACHE_BYTE_EN: byte store 0x80 to 0x41, then byte load 0x41:
//     -> rsp_rdata=32'hFFFF_FF80; word load 0x40 shows byte1=0x80.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate data cache; DCACHE_BYTE_EN adds sign-extended byte loads and byte stores
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 128
`endif
module data_cache #(
  parameter int NUM_LINES = 4,
  parameter int MEM_LATENCY = 5,
  parameter int LINE_WIDTH = `MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_wrt_en,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
`ifdef DCACHE_BYTE_EN
  input  logic                  req_byte,
`endif
  output logic [31:0]           rsp_rdata,
  output logic                  stall,
  output logic [31:0]           mem_addr,
  output logic [LINE_WIDTH-1:0] mem_data_to_write,
  output logic                  mem_wrt_en,
  input  logic [LINE_WIDTH-1:0] mem_data_to_read
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;
  state_t                state;
  logic [CW-1:0]         count;
  logic [LINE_WIDTH-1:0] data [NUM_LINES];
  logic [TW-1:0]         tags [NUM_LINES];
  logic [NUM_LINES-1:0]  valid, dirty;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag;
  logic                  hit;
  logic [LINE_WIDTH-1:0] line, wr_line;
  logic [31:0]           word, rd_sel;
  assign idx   = req_addr[4 +: IW];
  assign tag   = req_addr[31 -: TW];
  assign line  = data[idx];
  assign word  = line[{req_addr[3:2], 5'b0} +: 32];
  assign hit   = state == IDLE && req_valid && valid[idx] && tags[idx] == tag;
  assign stall = state != IDLE || (req_valid && !hit);
  assign rsp_rdata = hit ? rd_sel : 32'h0;
`ifdef DCACHE_BYTE_EN
  logic [7:0] byte_sel;
  assign byte_sel = line[{req_addr[3:0], 3'b0} +: 8];
  assign rd_sel   = req_byte ? {{24{byte_sel[7]}}, byte_sel} : word;
  always_comb begin
    wr_line = line;
    if (req_byte) wr_line[{req_addr[3:0], 3'b0} +: 8] = req_wdata[7:0];
    else wr_line[{req_addr[3:2], 5'b0} +: 32] = req_wdata;
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign rd_sel = word;
  always_comb begin
    wr_line = line;
    wr_line[{req_addr[3:2], 5'b0} +: 32] = req_wdata;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      valid             <= '0;
      dirty             <= '0;
      mem_wrt_en        <= 1'b0;
      mem_addr          <= '0;
      mem_data_to_write <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && req_wrt_en) begin
            data[idx]  <= wr_line;
            dirty[idx] <= 1'b1;
          end else if (req_valid && !hit) begin
            count <= CW'(MEM_LATENCY - 1);
            if (valid[idx] && dirty[idx]) begin
              state             <= EVICT;
              mem_wrt_en        <= 1'b1;
              mem_addr          <= {tags[idx], idx, 4'b0};
              mem_data_to_write <= line;
            end else begin
              state    <= FILL;
              mem_addr <= {req_addr[31:4], 4'b0};
            end
          end
        end
        EVICT: begin
          if (count == '0) begin
            dirty[idx] <= 1'b0;
            count      <= CW'(MEM_LATENCY - 1);
            state      <= FILL;
            mem_wrt_en <= 1'b0;
            mem_addr   <= {req_addr[31:4], 4'b0};
          end else count <= count - 1'b1;
        end
        FILL: begin
          if (count == '0) begin
            data[idx]  <= mem_data_to_read;
            tags[idx]  <= tag;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= IDLE;
          end else count <= count - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache with a behavioural main_memory
module tb_data_cache;
  localparam logic [127:0] L4  = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
  localparam logic [127:0] L4W = {32'h0000DDDD, 32'h0000CCCC, 32'h12345678, 32'h0000AAAA};
  localparam logic [127:0] L5  = {32'h53333333, 32'h52222222, 32'h51111111, 32'h50000000};
  localparam logic [127:0] L8  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] L12 = {32'hC0C00003, 32'hC0C00002, 32'hC0C00001, 32'hC0C00000};
  typedef struct {
    string        nm;
    logic         chk;
    logic [31:0]  rdata;
    int           stalls;
    int           wrs;
    logic [31:0]  wa;
    logic [127:0] wd;
  } exp_t;
  logic clk = 0, reset = 1, req_valid = 0, req_wrt_en = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, mem_addr;
  logic stall, mem_wrt_en;
  logic [127:0] mem_data_to_write, mem_data_to_read;
  logic [127:0] mem [16] = '{4: L4, 5: L5, 8: L8, 12: L12, default: '0};
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
`ifdef DCACHE_BYTE_EN
  logic req_byte = 0;
`endif
  data_cache dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_wrt_en(req_wrt_en),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef DCACHE_BYTE_EN
    .req_byte(req_byte),
`endif
    .rsp_rdata(rsp_rdata),
    .stall(stall),
    .mem_addr(mem_addr),
    .mem_data_to_write(mem_data_to_write),
    .mem_wrt_en(mem_wrt_en),
    .mem_data_to_read(mem_data_to_read)
  );
  always #5 clk = ~clk;
  assign mem_data_to_read = mem[mem_addr[7:4]];
  always @(posedge clk) if (mem_wrt_en) mem[mem_addr[7:4]] <= mem_data_to_write;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t ex(input string nm, input logic chk, input logic [31:0] rd, input int st,
                              input int wr, input logic [31:0] wa, input logic [127:0] wd);
    exp_t e;
    e.nm = nm; e.chk = chk; e.rdata = rd; e.stalls = st; e.wrs = wr; e.wa = wa; e.wd = wd;
    return e;
  endfunction
  // monitor: counts stall and write-back cycles per request, pops on completion
  int st_cnt = 0, wr_cnt = 0;
  logic [31:0] last_wa = 0;
  logic [127:0] last_wd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      st_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_wrt_en) begin
        wr_cnt++;
        last_wa = mem_addr;
        last_wd = mem_data_to_write;
      end
      if (req_valid && stall) st_cnt++;
      else if (req_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got response rdata %0h expected none", rsp_rdata);
        end else begin
          e = sb.pop_front();
          if (e.chk) check({e.nm, "_rdata"}, rsp_rdata, e.rdata);
          check({e.nm, "_stalls"}, st_cnt, e.stalls);
          check({e.nm, "_wb_cycles"}, wr_cnt, e.wrs);
          if (e.wrs > 0) begin
            check({e.nm, "_wb_addr"}, last_wa, e.wa);
            check({e.nm, "_wb_data"}, last_wd, e.wd);
          end
        end
        st_cnt = 0;
        wr_cnt = 0;
      end
    end
  end
  // requester must hold req_* stable while stalled
  logic p_stall = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_wd = 0;
  always @(posedge clk) begin
    if (!reset && p_stall && (!req_valid || req_addr !== p_addr || req_wrt_en !== p_we || req_wdata !== p_wd)) begin
      miscompares++;
      $display("FAIL protocol: req changed during stall at %0t", $time);
    end
    p_stall = !reset && stall && req_valid;
    p_addr = req_addr;
    p_we = req_wrt_en;
    p_wd = req_wdata;
  end
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic b, input exp_t e);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_addr = a;
    req_wrt_en = we;
    req_wdata = wd;
`ifdef DCACHE_BYTE_EN
    req_byte = b;
`else
    if (b) $display("note: byte request issued as word access");
`endif
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required completion", e.nm, n);
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_wrt_en", mem_wrt_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wdata", mem_data_to_write, 0);
    issue(32'h40, 0, 0, 0, ex("clean_miss", 1, 32'h0000AAAA, 6, 0, 0, 0));
    issue(32'h44, 1, 32'h12345678, 0, ex("store_hit", 0, 0, 0, 0, 0, 0));
    issue(32'h44, 0, 0, 0, ex("load_hit", 1, 32'h12345678, 0, 0, 0, 0));
    issue(32'h4C, 0, 0, 0, ex("load_word3", 1, 32'h0000DDDD, 0, 0, 0, 0));
    issue(32'h80, 0, 0, 0, ex("dirty_miss", 1, 32'h11111111, 11, 5, 32'h40, L4W));
    issue(32'h44, 0, 0, 0, ex("reload", 1, 32'h12345678, 6, 0, 0, 0));
    issue(32'h58, 1, 32'hCAFEF00D, 0, ex("store_miss", 0, 0, 6, 0, 0, 0));
    issue(32'h53, 0, 0, 0, ex("addr_lsb_ignored", 1, 32'h50000000, 0, 0, 0, 0));
    issue(32'h5B, 0, 0, 0, ex("store_alloc", 1, 32'hCAFEF00D, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    req_valid = 1;
    req_addr = 32'hC0;
    req_wrt_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fill_stall", stall, 1);
    check("fill_mem_addr", mem_addr, 32'hC0);
    @(posedge clk);
    #1;
    reset = 1;
    req_valid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("abort_stall", stall, 0);
    check("abort_wrt_en", mem_wrt_en, 0);
    check("abort_rdata", rsp_rdata, 0);
    issue(32'hC0, 0, 0, 0, ex("post_reset_miss", 1, 32'hC0C00000, 6, 0, 0, 0));
`ifdef DCACHE_BYTE_EN
    issue(32'h41, 1, 32'h80, 1, ex("byte_store", 0, 0, 6, 0, 0, 0));
    issue(32'h41, 0, 0, 1, ex("byte_load", 1, 32'hFFFFFF80, 0, 0, 0, 0));
    issue(32'h40, 0, 0, 0, ex("byte_merge", 1, 32'h000080AA, 0, 0, 0, 0));
`endif
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule
